// File: rtl/lsu_mc.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mc
// Description : Multi-cycle load/store unit. Accepts one request at a time
//               over a valid/ready issue handshake, computes the effective
//               address, aligns store data / strobes onto the memory byte
//               lanes, issues a request/grant/response memory transaction,
//               extracts and extends load data, and returns the result (or an
//               alignment / width / access-fault exception) to writeback.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid_i / req_ready_o     issue handshake
//   req_ls_i, req_wdth_i,         load/store select, size (1/2/4/8 bytes),
//   req_signed_i                  sign-extend loads
//   req_base_i, req_off_i         base address and signed offset
//   req_st_dat_i, req_rd_i        right-aligned store data, load destination
//   mem_req_o / mem_gnt_i         memory request / grant
//   mem_we_o, mem_addr_o,         write enable, bus-aligned address,
//   mem_wdat_o, mem_wstrb_o       lane-shifted store data and byte strobes
//   mem_rvalid_i, mem_rdat_i      memory response and bus-aligned read data
//   rsp_valid_o / rsp_ready_i     writeback handshake
//   rsp_wen_o, rsp_rd_o,          register write enable, destination,
//   rsp_dat_o                     extended load data
//   rsp_exc_o, rsp_cause_o,       exception flag and cause (0 load misalign,
//   rsp_addr_o                    1 store misalign, 2 illegal width,
//                                 3 access fault), effective address
// Optional feature macro:
//   LSU_TIMEOUT_EN  - watchdog in REQ/WAIT; after TIMEOUT_CYCLES cycles the
//                     transaction is abandoned with cause 3.
// ============================================================================
module lsu_mc #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 64,
  parameter int OFF_WIDTH      = 12,
  parameter int RD_WIDTH       = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_ls_i,
  input  logic [1:0]              req_wdth_i,
  input  logic                    req_signed_i,
  input  logic [ADDR_WIDTH-1:0]   req_base_i,
  input  logic [OFF_WIDTH-1:0]    req_off_i,
  input  logic [DATA_WIDTH-1:0]   req_st_dat_i,
  input  logic [RD_WIDTH-1:0]     req_rd_i,
  output logic                    mem_req_o,
  input  logic                    mem_gnt_i,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdat_o,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb_o,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdat_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic                    rsp_wen_o,
  output logic [RD_WIDTH-1:0]     rsp_rd_o,
  output logic [DATA_WIDTH-1:0]   rsp_dat_o,
  output logic                    rsp_exc_o,
  output logic [1:0]              rsp_cause_o,
  output logic [ADDR_WIDTH-1:0]   rsp_addr_o
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LANE_W = $clog2(STRB_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Registered request
  logic [ADDR_WIDTH-1:0] ea_q;
  logic                  ls_q;
  logic                  sgn_q;
  logic [1:0]            wdth_q;
  logic [DATA_WIDTH-1:0] st_dat_q;
  logic [RD_WIDTH-1:0]   rd_q;
  logic                  exc_q;
  logic [1:0]            cause_q;
  logic [DATA_WIDTH-1:0] rdat_q;

  // Combinational helpers
  logic [ADDR_WIDTH-1:0] ea_in;
  logic                  accept;
  logic [2:0]            align_mask;
  logic                  illegal_in;
  logic                  misalign_in;
  logic                  exc_in;
  logic [1:0]            cause_in;
  logic [LANE_W-1:0]     ea_low;
  logic [STRB_W-1:0]     size_mask;
  logic [DATA_WIDTH-1:0] ld_shift;
  logic [DATA_WIDTH-1:0] word_ext;
  logic [DATA_WIDTH-1:0] ld_ext;
  logic                  in_req;
  logic                  in_wait;
  logic                  in_resp;
  logic                  complete;
  logic                  timeout_hit;

  assign ea_in  = req_base_i + {{(ADDR_WIDTH-OFF_WIDTH){req_off_i[OFF_WIDTH-1]}}, req_off_i};
  assign accept = req_valid_i && (state == S_IDLE);

  always_comb begin
    align_mask = 3'b000;
    case (req_wdth_i)
      2'd0:    align_mask = 3'b000;
      2'd1:    align_mask = 3'b001;
      2'd2:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  end

  // An 8-byte access cannot be carried by a 32-bit bus.
  assign illegal_in  = (DATA_WIDTH == 32) && (req_wdth_i == 2'd3);
  assign misalign_in = |(ea_in[2:0] & align_mask);
  assign exc_in      = illegal_in || misalign_in;
  assign cause_in    = illegal_in  ? 2'd2 :
                       misalign_in ? (req_ls_i ? 2'd1 : 2'd0) : 2'd0;

  assign in_req   = (state == S_REQ);
  assign in_wait  = (state == S_WAIT);
  assign in_resp  = (state == S_RESP);
  assign complete = in_wait && mem_rvalid_i;

  assign ea_low = ea_q[LANE_W-1:0];

  always_comb begin
    size_mask = '0;
    case (wdth_q)
      2'd0:    size_mask = STRB_W'(8'h01);
      2'd1:    size_mask = STRB_W'(8'h03);
      2'd2:    size_mask = STRB_W'(8'h0F);
      default: size_mask = STRB_W'(8'hFF);
    endcase
  end

  // Load data: move the addressed lane down to bit 0, then extend.
  assign ld_shift = mem_rdat_i >> {ea_low, 3'b000};

  generate
    if (DATA_WIDTH > 32) begin : g_word_ext
      assign word_ext = {{(DATA_WIDTH-32){sgn_q & ld_shift[31]}}, ld_shift[31:0]};
    end else begin : g_word_full
      assign word_ext = ld_shift;
    end
  endgenerate

  always_comb begin
    ld_ext = ld_shift;
    case (wdth_q)
      2'd0:    ld_ext = {{(DATA_WIDTH-8){sgn_q & ld_shift[7]}},   ld_shift[7:0]};
      2'd1:    ld_ext = {{(DATA_WIDTH-16){sgn_q & ld_shift[15]}}, ld_shift[15:0]};
      2'd2:    ld_ext = word_ext;
      default: ld_ext = ld_shift;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int TO_W_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TO_W     = (TO_W_RAW < 8) ? 8 : ((TO_W_RAW > 16) ? 16 : TO_W_RAW);

  logic [TO_W-1:0] to_cnt;

  // The counter holds the number of REQ/WAIT cycles already elapsed, so the
  // limit is reached during the cycle in which to_cnt == TIMEOUT_CYCLES-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (accept) begin
      to_cnt <= '0;
    end else if (in_req || in_wait) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timeout_hit = (in_req || in_wait) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a response in WAIT wins over a simultaneous timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = exc_in ? S_RESP : S_REQ;
      S_REQ: begin
        if (timeout_hit)    state_nxt = S_RESP;
        else if (mem_gnt_i) state_nxt = S_WAIT;
      end
      S_WAIT: if (mem_rvalid_i || timeout_hit) state_nxt = S_RESP;
      default: if (rsp_ready_i) state_nxt = S_IDLE;
    endcase
  end

  // Request capture and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ea_q     <= '0;
      ls_q     <= 1'b0;
      sgn_q    <= 1'b0;
      wdth_q   <= 2'd0;
      st_dat_q <= '0;
      rd_q     <= '0;
      exc_q    <= 1'b0;
      cause_q  <= 2'd0;
      rdat_q   <= '0;
    end else if (accept) begin
      ea_q     <= ea_in;
      ls_q     <= req_ls_i;
      sgn_q    <= req_signed_i;
      wdth_q   <= req_wdth_i;
      st_dat_q <= req_st_dat_i;
      rd_q     <= req_rd_i;
      exc_q    <= exc_in;
      cause_q  <= cause_in;
      rdat_q   <= '0;
    end else if (complete) begin
      // rdat_q stays zero for stores, so rsp_dat_o needs no extra gating.
      if (!ls_q) rdat_q <= ld_ext;
    end else if (timeout_hit) begin
      exc_q   <= 1'b1;
      cause_q <= 2'd3;
    end
  end

  // Outputs are gated by state so every output is zero outside its phase,
  // which also gives the required all-zero values immediately on reset.
  assign req_ready_o = (state == S_IDLE);

  assign mem_req_o   = in_req;
  assign mem_we_o    = in_req && ls_q;
  assign mem_addr_o  = in_req ? {ea_q[ADDR_WIDTH-1:LANE_W], {LANE_W{1'b0}}} : '0;
  assign mem_wdat_o  = (in_req && ls_q) ? (st_dat_q << {ea_low, 3'b000}) : '0;
  assign mem_wstrb_o = (in_req && ls_q) ? (size_mask << ea_low) : '0;

  assign rsp_valid_o = in_resp;
  assign rsp_wen_o   = in_resp && !ls_q && !exc_q;
  assign rsp_rd_o    = in_resp ? rd_q : '0;
  assign rsp_dat_o   = (in_resp && !exc_q) ? rdat_q : '0;
  assign rsp_exc_o   = in_resp && exc_q;
  assign rsp_cause_o = (in_resp && exc_q) ? cause_q : 2'd0;
  assign rsp_addr_o  = in_resp ? ea_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_mc
// Description : Self-checking bench for lsu_mc (DATA_WIDTH 64, default build).
//               Directed cases plus randomized loads/stores compared against a
//               byte-level reference model of address, lane and extension rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_mc;

  logic        clk;
  logic        rst_n;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_ls_i;
  logic [1:0]  req_wdth_i;
  logic        req_signed_i;
  logic [31:0] req_base_i;
  logic [11:0] req_off_i;
  logic [63:0] req_st_dat_i;
  logic [4:0]  req_rd_i;
  logic        mem_req_o;
  logic        mem_gnt_i;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [63:0] mem_wdat_o;
  logic [7:0]  mem_wstrb_o;
  logic        mem_rvalid_i;
  logic [63:0] mem_rdat_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic        rsp_wen_o;
  logic [4:0]  rsp_rd_o;
  logic [63:0] rsp_dat_o;
  logic        rsp_exc_o;
  logic [1:0]  rsp_cause_o;
  logic [31:0] rsp_addr_o;

  int errors = 0;
  int checks = 0;

  // Values observed in the most recent transaction, for directed constants.
  logic [63:0] last_dat;
  logic [31:0] last_maddr;
  logic [63:0] last_wdat;
  logic [7:0]  last_strb;

  lsu_mc #(
    .ADDR_WIDTH(32), .DATA_WIDTH(64), .OFF_WIDTH(12), .RD_WIDTH(5), .TIMEOUT_CYCLES(255)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_ls_i(req_ls_i), .req_wdth_i(req_wdth_i), .req_signed_i(req_signed_i),
    .req_base_i(req_base_i), .req_off_i(req_off_i), .req_st_dat_i(req_st_dat_i),
    .req_rd_i(req_rd_i),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdat_o(mem_wdat_o), .mem_wstrb_o(mem_wstrb_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdat_i(mem_rdat_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_wen_o(rsp_wen_o),
    .rsp_rd_o(rsp_rd_o), .rsp_dat_o(rsp_dat_o), .rsp_exc_o(rsp_exc_o),
    .rsp_cause_o(rsp_cause_o), .rsp_addr_o(rsp_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: pick the addressed bytes of the bus word and extend them.
  function automatic logic [63:0] ref_load(input logic [63:0] rdat, input int low,
                                           input int size, input bit sgn);
    logic [63:0] v;
    logic [63:0] keep;
    v = rdat >> (8 * low);
    if (size == 8) return v;
    keep = (64'd1 << (8 * size)) - 64'd1;
    v = v & keep;
    if (sgn && v[8*size-1]) v = v | ~keep;
    return v;
  endfunction

  task automatic run_txn(input bit ls, input logic [1:0] w, input bit sg,
                         input logic [31:0] base, input logic [11:0] off,
                         input logic [63:0] st, input logic [4:0] rd,
                         input logic [63:0] rdat, input int gdly, input int rdly,
                         input int bp);
    int          o;
    int          size;
    int          low;
    bit          mis;
    logic [31:0] ea;
    logic [63:0] exp_dat;
    logic [7:0]  exp_strb;
    logic [63:0] exp_wdat;
    o    = int'($signed(off));
    ea   = base + 32'(o);
    size = 1 << w;
    low  = int'(ea[2:0]);
    mis  = (ea % size) != 0;
    for (int b = 0; b < 8; b++) exp_strb[b] = ls && (b >= low) && (b < low + size);
    exp_wdat = ls ? (st << (8 * low)) : 64'd0;
    exp_dat  = (ls || mis) ? 64'd0 : ref_load(rdat, low, size, sg);

    chk("req_ready_idle", {63'd0, req_ready_o}, 64'd1);
    req_valid_i  = 1'b1;
    req_ls_i     = ls;
    req_wdth_i   = w;
    req_signed_i = sg;
    req_base_i   = base;
    req_off_i    = off;
    req_st_dat_i = st;
    req_rd_i     = rd;
    @(negedge clk);
    // Scramble the request bus: the DUT must use its registered copy.
    req_valid_i  = 1'b0;
    req_ls_i     = 1'($urandom);
    req_wdth_i   = 2'($urandom);
    req_base_i   = $urandom;
    req_off_i    = 12'($urandom);
    req_st_dat_i = {$urandom, $urandom};
    req_rd_i     = 5'($urandom);

    if (mis) begin
      chk("exc_mem_req", {63'd0, mem_req_o}, 64'd0);
      chk("exc_rsp_valid", {63'd0, rsp_valid_o}, 64'd1);
      chk("exc_flag", {63'd0, rsp_exc_o}, 64'd1);
      chk("exc_cause", {62'd0, rsp_cause_o}, ls ? 64'd1 : 64'd0);
    end else begin
      for (int k = 0; k <= gdly; k++) begin
        chk("req_mem_req", {63'd0, mem_req_o}, 64'd1);
        chk("req_addr", {32'd0, mem_addr_o}, {32'd0, ea & 32'hFFFF_FFF8});
        chk("req_we", {63'd0, mem_we_o}, {63'd0, ls});
        chk("req_strb", {56'd0, mem_wstrb_o}, {56'd0, exp_strb});
        chk("req_wdat", mem_wdat_o, exp_wdat);
        chk("req_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
        if (k == 0) begin
          last_maddr = mem_addr_o;
          last_wdat  = mem_wdat_o;
          last_strb  = mem_wstrb_o;
        end
        if (k == gdly) begin
          mem_gnt_i    = 1'b1;
          mem_rvalid_i = 1'b0;
        end else begin
          mem_gnt_i    = 1'b0;
          mem_rvalid_i = 1'($urandom);   // must be ignored outside WAIT
          mem_rdat_i   = {$urandom, $urandom};
        end
        @(negedge clk);
      end
      mem_gnt_i = 1'b0;
      for (int k = 0; k <= rdly; k++) begin
        chk("wait_mem_req", {63'd0, mem_req_o}, 64'd0);
        chk("wait_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
        if (k == rdly) begin
          mem_rvalid_i = 1'b1;
          mem_rdat_i   = rdat;
        end else begin
          mem_rvalid_i = 1'b0;
          mem_rdat_i   = {$urandom, $urandom};
        end
        @(negedge clk);
      end
      mem_rvalid_i = 1'b0;
      mem_rdat_i   = {$urandom, $urandom};
      chk("rsp_valid", {63'd0, rsp_valid_o}, 64'd1);
      chk("rsp_exc", {63'd0, rsp_exc_o}, 64'd0);
      chk("rsp_rd", {59'd0, rsp_rd_o}, {59'd0, rd});
    end

    for (int k = 0; k <= bp; k++) begin
      if (k > 0) @(negedge clk);
      chk("rsp_hold_valid", {63'd0, rsp_valid_o}, 64'd1);
      chk("rsp_req_ready", {63'd0, req_ready_o}, 64'd0);
      chk("rsp_wen", {63'd0, rsp_wen_o}, {63'd0, !ls && !mis});
      chk("rsp_dat", rsp_dat_o, exp_dat);
      chk("rsp_addr", {32'd0, rsp_addr_o}, {32'd0, ea});
    end
    last_dat    = rsp_dat_o;
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    chk("retire_valid", {63'd0, rsp_valid_o}, 64'd0);
    chk("retire_ready", {63'd0, req_ready_o}, 64'd1);
  endtask

  initial begin
    logic [1:0]  w;
    logic [31:0] ea;
    logic [11:0] off;
    int          sz;

    rst_n        = 1'b0;
    req_valid_i  = 1'b0;
    req_ls_i     = 1'b0;
    req_wdth_i   = 2'd0;
    req_signed_i = 1'b0;
    req_base_i   = '0;
    req_off_i    = '0;
    req_st_dat_i = '0;
    req_rd_i     = '0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdat_i   = '0;
    rsp_ready_i  = 1'b0;
    last_dat     = '0;
    last_maddr   = '0;
    last_wdat    = '0;
    last_strb    = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {63'd0, req_ready_o}, 64'd1);
    chk("rst_mem_req", {63'd0, mem_req_o}, 64'd0);
    chk("rst_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
    chk("rst_mem_addr", {32'd0, mem_addr_o}, 64'd0);
    chk("rst_rsp_dat", rsp_dat_o, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Signed byte load from lane 7: ea 0x1007
    run_txn(1'b0, 2'd0, 1'b1, 32'h0000_1008, 12'hFFF, 64'd0, 5'd3,
            64'h8011_2233_4455_6677, 0, 0, 0);
    chk("tp_lb_addr", {32'd0, last_maddr}, 64'h0000_1000);
    chk("tp_lb_dat", last_dat, 64'hFFFF_FFFF_FFFF_FF80);

    // Half store at ea 0x2006, immediate grant
    run_txn(1'b1, 2'd1, 1'b0, 32'h0000_2000, 12'h006, 64'h0000_0000_0000_ABCD, 5'd0,
            64'd0, 0, 0, 0);
    chk("tp_sh_strb", {56'd0, last_strb}, 64'hC0);
    chk("tp_sh_wdat", last_wdat, 64'hABCD_0000_0000_0000);

    // Misaligned word load: exception path
    run_txn(1'b0, 2'd2, 1'b0, 32'h0000_3000, 12'h002, 64'd0, 5'd7, 64'd0, 0, 0, 0);

    // Backpressure: response held for 5 cycles
    run_txn(1'b0, 2'd2, 1'b1, 32'h0000_4000, 12'h004, 64'd0, 5'd9,
            64'h9876_5432_0000_0000, 1, 2, 5);
    chk("tp_bp_dat", last_dat, 64'hFFFF_FFFF_9876_5432);

    // Unsigned doubleword load passes through
    run_txn(1'b0, 2'd3, 1'b0, 32'h0000_5000, 12'h010, 64'd0, 5'd1,
            64'hF00D_CAFE_1234_5678, 2, 1, 1);
    chk("tp_ld_dat", last_dat, 64'hF00D_CAFE_1234_5678);

    // Reset mid-REQ: mem_req_o must drop without waiting for a clock edge
    req_valid_i = 1'b1; req_ls_i = 1'b0; req_wdth_i = 2'd2;
    req_base_i  = 32'h0000_6000; req_off_i = 12'h000;
    @(negedge clk);
    req_valid_i = 1'b0;
    chk("rreq_mem_req", {63'd0, mem_req_o}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rreq_mem_req_drop", {63'd0, mem_req_o}, 64'd0);
    chk("rreq_req_ready", {63'd0, req_ready_o}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset mid-WAIT, then a late response must be ignored
    req_valid_i = 1'b1; req_ls_i = 1'b0; req_wdth_i = 2'd0;
    req_base_i  = 32'h0000_7000; req_off_i = 12'h001;
    @(negedge clk);
    req_valid_i = 1'b0;
    mem_gnt_i   = 1'b1;
    @(negedge clk);
    mem_gnt_i = 1'b0;
    chk("rwait_in_wait", {62'd0, mem_req_o, req_ready_o}, 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rwait_mem_req", {63'd0, mem_req_o}, 64'd0);
    chk("rwait_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
    chk("rwait_req_ready", {63'd0, req_ready_o}, 64'd1);
    @(negedge clk);
    rst_n        = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdat_i   = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("late_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
      chk("late_req_ready", {63'd0, req_ready_o}, 64'd1);
      @(negedge clk);
    end

    // Randomized transactions, mostly aligned
    for (int n = 0; n < 40; n++) begin
      w   = 2'($urandom);
      sz  = 1 << w;
      ea  = $urandom;
      if (($urandom % 4) != 0) ea = ea & ~32'(sz - 1);
      off = 12'($urandom);
      run_txn(1'($urandom), w, 1'($urandom), ea - 32'(int'($signed(off))), off,
              {$urandom, $urandom}, 5'($urandom), {$urandom, $urandom},
              int'($urandom % 3), int'($urandom % 3), int'($urandom % 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
